// File: rtl/spectrum_bar_renderer.sv
// Spectrum bar renderer: draws NUM_BARS vertical magnitude bars from a
// double-buffered bin memory onto a 640x480 timing stream, 3-cycle pixel latency.
module spectrum_bar_renderer #(
    parameter int          NUM_BARS  = 64,
    parameter int          BAR_WIDTH = 10,
    parameter int          MAG_WIDTH = 9,
    parameter int          V_ACTIVE  = 480,
    parameter logic [11:0] BAR_COLOR = 12'h0F0,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic                        pixel_clk,
    input  logic                        reset,
    input  logic                        bin_wr_en,
    input  logic [$clog2(NUM_BARS)-1:0] bin_wr_addr,
    input  logic [MAG_WIDTH-1:0]        bin_wr_data,
    input  logic                        bin_frame_done,
    output logic                        busy,
    input  logic [9:0]                  pixel_x,
    input  logic [9:0]                  pixel_y,
    input  logic                        video_on,
    input  logic                        frame_over,
    input  logic                        h_sync_in,
    input  logic                        v_sync_in,
    output logic [11:0]                 rgb,
    output logic                        h_sync_out,
    output logic                        v_sync_out
);

    localparam int AW = $clog2(NUM_BARS);
    localparam int BW = AW + 1;
    localparam int OW = $clog2(BAR_WIDTH);

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    localparam logic [10:0]          V_ACT11   = 11'(V_ACTIVE);
    localparam logic [MAG_WIDTH-1:0] MAG_CEIL  = MAG_WIDTH'(V_ACTIVE);
    localparam logic [OW-1:0]        OFFS_LAST = OW'(BAR_WIDTH - 1);
    localparam logic [BW-1:0]        BAR_END   = BW'(NUM_BARS);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          display_sel_q, display_sel_d;
    logic          clr_we, fill_we;

    // Write valid/ready: a bin_wr_en beat is taken only in a cycle where busy
    // is low; beats offered while busy is high are dropped, never stalled.
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        display_sel_d = display_sel_q;
        clr_we        = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(NUM_BARS - 1)) state_d = ST_FILL;
            end
            ST_FILL: begin
                fill_we = bin_wr_en;
                if (bin_frame_done) begin
                    if (frame_over) display_sel_d = ~display_sel_q;
                    else            state_d       = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_over) begin
                    display_sel_d = ~display_sel_q;
                    state_d       = ST_FILL;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            display_sel_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            display_sel_q <= display_sel_d;
        end
    end

    assign busy = (state_q != ST_FILL);

    logic [MAG_WIDTH-1:0] wr_mag, wr_data;
    logic [AW-1:0]        wr_addr;
    logic                 bank0_we, bank1_we;

    always_comb begin
        wr_mag   = (32'(bin_wr_data) > V_ACTIVE) ? MAG_CEIL : bin_wr_data;
        wr_addr  = clr_we ? clr_addr_q : bin_wr_addr;
        wr_data  = clr_we ? '0 : wr_mag;
        // The back bank is the one not on display.
        bank0_we = clr_we | (fill_we & display_sel_q);
        bank1_we = clr_we | (fill_we & ~display_sel_q);
    end

    // S1: column counter replaces a divide by BAR_WIDTH.
    logic [BW-1:0] col_bar_q, col_bar_d, cur_bar;
    logic [OW-1:0] col_offs_q, col_offs_d, cur_offs;
    logic [BW-1:0] s1_bar_q, s1_bar_d;
    logic [9:0]    s1_y_q, s1_y_d;
    logic          s1_von_q, s1_von_d, s1_inbar_q, s1_inbar_d;

    always_comb begin
        cur_bar  = (pixel_x == 10'd0) ? '0 : col_bar_q;
        cur_offs = (pixel_x == 10'd0) ? '0 : col_offs_q;
        if (cur_offs == OFFS_LAST) begin
            col_offs_d = '0;
            col_bar_d  = (cur_bar == BAR_END) ? cur_bar : cur_bar + BW'(1);
        end else begin
            col_offs_d = cur_offs + OW'(1);
            col_bar_d  = cur_bar;
        end
        s1_bar_d   = cur_bar;
        s1_y_d     = pixel_y;
        s1_von_d   = video_on;
        s1_inbar_d = (cur_bar < BAR_END) && (cur_offs != OFFS_LAST);
    end

    logic [MAG_WIDTH-1:0] bank0_mem [NUM_BARS];
    logic [MAG_WIDTH-1:0] bank1_mem [NUM_BARS];
    logic [MAG_WIDTH-1:0] bank0_rd_q, bank1_rd_q;

    always_ff @(posedge pixel_clk) begin
        if (bank0_we) bank0_mem[wr_addr] <= wr_data;
        bank0_rd_q <= bank0_mem[s1_bar_q[AW-1:0]];
    end

    always_ff @(posedge pixel_clk) begin
        if (bank1_we) bank1_mem[wr_addr] <= wr_data;
        bank1_rd_q <= bank1_mem[s1_bar_q[AW-1:0]];
    end

    // S2 flags travel alongside the synchronous bank read.
    logic [9:0]           s2_y_q, s2_y_d;
    logic                 s2_von_q, s2_von_d, s2_inbar_q, s2_inbar_d, s2_sel_q, s2_sel_d;
    logic [MAG_WIDTH-1:0] mag;
    logic                 lit;
    logic [11:0]          rgb_q, rgb_d;
    logic                 hs1_q, hs1_d, hs2_q, hs2_d, vs1_q, vs1_d, vs2_q, vs2_d;

    always_comb begin
        s2_y_d     = s1_y_q;
        s2_von_d   = s1_von_q;
        s2_inbar_d = s1_inbar_q;
        s2_sel_d   = display_sel_q;
        mag        = s2_sel_q ? bank1_rd_q : bank0_rd_q;
        // y >= V_ACTIVE - mag, rearranged to avoid an unsigned underflow.
        lit        = s2_inbar_q && (state_q != ST_CLEAR) &&
                     (({1'b0, s2_y_q} + 11'(mag)) >= V_ACT11);
        rgb_d      = !s2_von_q ? 12'h000 : (lit ? BAR_COLOR : BG_COLOR);
        hs1_d      = h_sync_in;
        hs2_d      = hs1_q;
        vs1_d      = v_sync_in;
        vs2_d      = vs1_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            col_bar_q  <= '0;
            col_offs_q <= '0;
            s1_bar_q   <= '0;
            s1_y_q     <= '0;
            s1_von_q   <= 1'b0;
            s1_inbar_q <= 1'b0;
            s2_y_q     <= '0;
            s2_von_q   <= 1'b0;
            s2_inbar_q <= 1'b0;
            s2_sel_q   <= 1'b0;
            rgb_q      <= '0;
            hs1_q      <= 1'b1;
            hs2_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vs2_q      <= 1'b1;
        end else begin
            col_bar_q  <= col_bar_d;
            col_offs_q <= col_offs_d;
            s1_bar_q   <= s1_bar_d;
            s1_y_q     <= s1_y_d;
            s1_von_q   <= s1_von_d;
            s1_inbar_q <= s1_inbar_d;
            s2_y_q     <= s2_y_d;
            s2_von_q   <= s2_von_d;
            s2_inbar_q <= s2_inbar_d;
            s2_sel_q   <= s2_sel_d;
            rgb_q      <= rgb_d;
            hs1_q      <= hs1_d;
            hs2_q      <= hs2_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
        end
    end

    assign rgb        = rgb_q;
    assign h_sync_out = hs2_q;
    assign v_sync_out = vs2_q;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Directed bench for spectrum_bar_renderer: clear timing, bank swapping,
// clamp, gap columns, sync alignment and mid-frame reset.
module tb_spectrum_bar_renderer;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b0;
    logic        bin_wr_en = 1'b0;
    logic [5:0]  bin_wr_addr = '0;
    logic [8:0]  bin_wr_data = '0;
    logic        bin_frame_done = 1'b0;
    logic        busy;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        video_on = 1'b0;
    logic        frame_over = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] row_rgb [0:639];
    logic [15:0] hpat = 16'b1011_0010_1110_0101;
    logic [15:0] vpat = 16'b0110_1000_1101_1010;

    always #20 pixel_clk = ~pixel_clk;

    spectrum_bar_renderer dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .bin_wr_en      (bin_wr_en),
        .bin_wr_addr    (bin_wr_addr),
        .bin_wr_data    (bin_wr_data),
        .bin_frame_done (bin_frame_done),
        .busy           (busy),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .video_on       (video_on),
        .frame_over     (frame_over),
        .h_sync_in      (h_sync_in),
        .v_sync_in      (v_sync_in),
        .rgb            (rgb),
        .h_sync_out     (h_sync_out),
        .v_sync_out     (v_sync_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All driver tasks start and end on a falling edge.
    task automatic write_bin(input int addr, input int data);
        bin_wr_en   = 1'b1;
        bin_wr_addr = 6'(addr);
        bin_wr_data = 9'(data);
        @(negedge pixel_clk);
        bin_wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        bin_frame_done = 1'b1;
        @(negedge pixel_clk);
        bin_frame_done = 1'b0;
    endtask

    task automatic pulse_frame_over();
        frame_over = 1'b1;
        @(negedge pixel_clk);
        frame_over = 1'b0;
    endtask

    // rgb sampled now belongs to the x driven three falling edges earlier.
    task automatic scan_row(input int y, input logic von);
        pixel_y = 10'(y);
        for (int i = 0; i < 643; i++) begin
            if (i >= 3) row_rgb[i-3] = rgb;
            pixel_x  = 10'(i);
            video_on = von && (i < 640);
            @(negedge pixel_clk);
        end
        video_on = 1'b0;
    endtask

    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < 640; i++) if (row_rgb[i] != 12'h000) n++;
        return n;
    endfunction

    task automatic reset_and_clear(input string tag);
        int n;
        reset = 1'b1;
        @(negedge pixel_clk);
        chk({tag, "_busy_in_reset"}, 32'(busy), 32'd1);
        chk({tag, "_rgb_in_reset"}, 32'(rgb), 32'h000);
        chk({tag, "_hs_in_reset"}, 32'(h_sync_out), 32'd1);
        chk({tag, "_vs_in_reset"}, 32'(v_sync_out), 32'd1);
        reset = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge pixel_clk);
        end
        chk({tag, "_clear_cycles"}, 32'(n), 32'd64);
    endtask

    initial begin
        repeat (2) @(negedge pixel_clk);

        // Reset and CLEAR timing, blank screen after clear.
        reset_and_clear("por");
        scan_row(479, 1'b1);
        chk("por_row479_lit", 32'(count_nonzero()), 32'd0);
        scan_row(0, 1'b1);
        chk("por_row0_lit", 32'(count_nonzero()), 32'd0);

        // bin0=100 into bank1, then swap to display it.
        write_bin(0, 100);
        pulse_done();
        chk("pending_busy", 32'(busy), 32'd1);
        pulse_frame_over();
        chk("swap1_busy", 32'(busy), 32'd0);
        scan_row(380, 1'b1);
        chk("b0_y380_x0", 32'(row_rgb[0]), 32'h0F0);
        chk("b0_y380_x8", 32'(row_rgb[8]), 32'h0F0);
        chk("b0_y380_x9_gap", 32'(row_rgb[9]), 32'h000);
        chk("b0_y380_x10", 32'(row_rgb[10]), 32'h000);
        scan_row(379, 1'b1);
        chk("b0_y379_x0", 32'(row_rgb[0]), 32'h000);
        scan_row(400, 1'b1);
        chk("b0_y400_x9_gap", 32'(row_rgb[9]), 32'h000);
        chk("b0_y400_x5", 32'(row_rgb[5]), 32'h0F0);

        // Write offered while PENDING is dropped.
        pulse_done();
        chk("pend2_busy", 32'(busy), 32'd1);
        write_bin(3, 50);
        pulse_frame_over();
        chk("swap2_busy", 32'(busy), 32'd0);
        scan_row(470, 1'b1);
        chk("bank0_y470_x30", 32'(row_rgb[30]), 32'h000);
        chk("bank0_y470_x0", 32'(row_rgb[0]), 32'h000);
        chk("bank0_y470_lit", 32'(count_nonzero()), 32'd0);

        // Fill bank1, then write+done+frame_over in one cycle (clamped bin63).
        write_bin(3, 50);
        bin_wr_en      = 1'b1;
        bin_wr_addr    = 6'd63;
        bin_wr_data    = 9'd511;
        bin_frame_done = 1'b1;
        frame_over     = 1'b1;
        chk("same_cycle_busy_before", 32'(busy), 32'd0);
        @(negedge pixel_clk);
        bin_wr_en      = 1'b0;
        bin_frame_done = 1'b0;
        frame_over     = 1'b0;
        chk("same_cycle_busy_after", 32'(busy), 32'd0);
        scan_row(470, 1'b1);
        chk("b1_y470_x0", 32'(row_rgb[0]), 32'h0F0);
        chk("b1_y470_x29_gap", 32'(row_rgb[29]), 32'h000);
        chk("b1_y470_x30", 32'(row_rgb[30]), 32'h0F0);
        chk("b1_y470_x38", 32'(row_rgb[38]), 32'h0F0);
        chk("b1_y470_x39_gap", 32'(row_rgb[39]), 32'h000);
        chk("b1_y470_x630", 32'(row_rgb[630]), 32'h0F0);
        chk("b1_y470_x639_gap", 32'(row_rgb[639]), 32'h000);
        chk("b1_y470_lit", 32'(count_nonzero()), 32'd27);
        scan_row(0, 1'b1);
        chk("clamp_y0_x630", 32'(row_rgb[630]), 32'h0F0);
        chk("clamp_y0_x638", 32'(row_rgb[638]), 32'h0F0);
        chk("clamp_y0_x639", 32'(row_rgb[639]), 32'h000);
        chk("clamp_y0_x0", 32'(row_rgb[0]), 32'h000);
        chk("clamp_y0_lit", 32'(count_nonzero()), 32'd9);
        scan_row(479, 1'b1);
        chk("clamp_y479_x638", 32'(row_rgb[638]), 32'h0F0);
        scan_row(429, 1'b1);
        chk("b3_y429_x30", 32'(row_rgb[30]), 32'h000);
        scan_row(430, 1'b1);
        chk("b3_y430_x30", 32'(row_rgb[30]), 32'h0F0);
        scan_row(470, 1'b0);
        chk("video_off_lit", 32'(count_nonzero()), 32'd0);

        // Sync outputs trail the inputs by exactly two cycles.
        for (int i = 0; i < 18; i++) begin
            if (i >= 2) begin
                chk($sformatf("hsync_%0d", i - 2), 32'(h_sync_out), 32'(hpat[i-2]));
                chk($sformatf("vsync_%0d", i - 2), 32'(v_sync_out), 32'(vpat[i-2]));
            end
            h_sync_in = (i < 16) ? hpat[i] : 1'b1;
            v_sync_in = (i < 16) ? vpat[i] : 1'b1;
            @(negedge pixel_clk);
        end

        // Reset in the middle of a visible line wipes both banks.
        pixel_x  = 10'd100;
        pixel_y  = 10'd470;
        video_on = 1'b1;
        reset_and_clear("mid");
        video_on = 1'b0;
        scan_row(470, 1'b1);
        chk("mid_y470_lit", 32'(count_nonzero()), 32'd0);
        scan_row(0, 1'b1);
        chk("mid_y0_lit", 32'(count_nonzero()), 32'd0);
        pulse_done();
        pulse_frame_over();
        scan_row(470, 1'b1);
        chk("mid_other_bank_lit", 32'(count_nonzero()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_renderer.md
Name: spectrum_bar_renderer

Overview:
- Consumes the 640x480@60 Hz timing stream (pixel_x, pixel_y, video_on, frame_over, h_sync, v_sync) and produces 12-bit RGB.
- Draws NUM_BARS vertical magnitude bars from a double-buffered bin memory.
- The upstream FFT/magnitude stage fills the back bank, already in the pixel_clk domain. The bank swap happens only on frame_over, so a frame never tears.

Parameters:
- NUM_BARS, 64, number of bars/bins; power of 2.
- BAR_WIDTH, 10, pixels per bar including a 1-pixel gap column; NUM_BARS*BAR_WIDTH <= 640.
- MAG_WIDTH, 9, bin magnitude width in bits.
- V_ACTIVE, 480, visible rows; this is the clamp ceiling for magnitudes.
- BAR_COLOR, 12'h0F0, RGB444 colour of lit bar pixels.
- BG_COLOR, 12'h000, RGB444 colour of unlit visible pixels.

Ports:
- pixel_clk, in, 1, 25 MHz pixel clock; the only clock.
- reset, in, 1, synchronous, active-high.
- bin_wr_en, in, 1, write strobe for the back bank.
- bin_wr_addr, in, log2(NUM_BARS), bin index.
- bin_wr_data, in, MAG_WIDTH, bin magnitude.
- bin_frame_done, in, 1, 1-cycle pulse: back bank complete, request swap.
- busy, out, 1, high in CLEAR or PENDING; writes are ignored while high.
- pixel_x, in, 10, current column from the timing generator.
- pixel_y, in, 10, current row from the timing generator.
- video_on, in, 1, visible-area flag.
- frame_over, in, 1, 1-cycle swap window at VSYNC start.
- h_sync_in, in, 1, registered HSYNC (one cycle behind pixel_x/pixel_y).
- v_sync_in, in, 1, registered VSYNC (one cycle behind pixel_x/pixel_y).
- rgb, out, 12, pixel colour {R4,G4,B4}.
- h_sync_out, in/out alignment: out, 1, HSYNC aligned to rgb.
- v_sync_out, out, 1, VSYNC aligned to rgb.

Behaviour:
- Storage: two banks of NUM_BARS x MAG_WIDTH with synchronous read, mapped to block RAM. display_sel selects the front bank; writes always target bank ~display_sel.
- Write clamp: stored value = min(bin_wr_data, V_ACTIVE).
- FSM states are CLEAR, FILL, PENDING.
  - reset -> CLEAR. clr_addr=0, display_sel=0, busy=1, rgb=0, h_sync_out=1, v_sync_out=1, pipeline valid bits=0.
  - CLEAR: write 0 to clr_addr in both banks, one address per cycle. After address NUM_BARS-1 -> FILL, so CLEAR lasts exactly NUM_BARS cycles.
  - FILL: busy=0. Accept bin_wr_en writes. bin_frame_done -> PENDING.
  - PENDING: busy=1 and writes are dropped. On frame_over, toggle display_sel -> FILL.
- Simultaneous events:
  - bin_frame_done and frame_over in the same FILL cycle: swap that cycle, stay in FILL.
  - A bin_wr_en in that same cycle is still written to the old back bank before the swap.
  - bin_frame_done in CLEAR or PENDING: ignored.
- reset mid-frame or mid-fill aborts everything and restarts CLEAR; bank contents are rewritten to 0.
- Render pipeline: fixed 3-cycle latency from pixel_x/pixel_y/video_on to rgb.
  - S1: column counter produces bar_idx = pixel_x / BAR_WIDTH and offs = pixel_x % BAR_WIDTH. It resets when pixel_x==0, increments offs, and wraps offs at BAR_WIDTH-1 with bar_idx+1. No divider. Register pixel_y, video_on and in_bar = (bar_idx < NUM_BARS) && (offs != BAR_WIDTH-1).
  - S2: front-bank read at bar_idx; carry S1 flags forward.
  - S3: lit = in_bar && (pixel_y >= V_ACTIVE - mag). rgb = !video_on ? 0 : (lit ? BAR_COLOR : BG_COLOR).
- While in CLEAR, lit is forced to 0.
- h_sync_out/v_sync_out are h_sync_in/v_sync_in delayed 2 cycles, which aligns them with rgb.
- Magnitude 0 lights no pixel. Magnitude V_ACTIVE lights the whole column (rows 0..479).
- display_sel changes only on frame_over, inside vertical blanking, so the pipeline never mixes banks within a visible frame.

Test Plan:
1. Reset for 1 cycle, then run: busy=1 for exactly 64 cycles, then 0. All visible rgb=12'h000. rgb=0 whenever video_on=0.
2. Write bin0=100, pulse bin_frame_done, then wait for frame_over. Next frame: pixel (0,380) gives rgb=12'h0F0 three cycles after its coordinates; (0,379) gives 12'h000; (9,400) (gap column) gives 12'h000.
3. Write bin3=50 while busy=1 (PENDING): after the swap and the next fill, bin3 still reads its previous value, so pixel (30,470) is unlit.
4. Pulse bin_frame_done and frame_over in the same cycle: display_sel toggles that cycle, busy stays 0, and the new bars show in the next frame.
5. Write bin63=511: stored value is 480. Column 630..638 is lit for rows 0..479 and column 639 is dark.
6. Toggle h_sync_in/v_sync_in arbitrarily: h_sync_out/v_sync_out equal the inputs delayed exactly 2 cycles. Assert reset mid-frame: busy=1 and the 64-cycle CLEAR reruns with all bars dark.
